// File: rtl/mc_control_fsm_pkg.sv
// Shared types for the multi-cycle RISC-V control path: opcodes, ALU ops,
// FSM states and datapath mux selects.
package mc_control_fsm_pkg;

    typedef enum logic [6:0] {
        OpLoad  = 7'b0000011,
        OpStore = 7'b0100011,
        OpRType = 7'b0110011,
        OpIType = 7'b0010011,
        OpBType = 7'b1100011,
        OpJal   = 7'b1101111
    } ty_OPCODE;

    typedef enum logic [3:0] {
        AluAdd = 4'b0000,
        AluSub = 4'b1000,
        AluXor = 4'b0100,
        AluOr  = 4'b0110,
        AluAnd = 4'b0111
    } ty_ALU_OP;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecuteR,
        StExecuteI,
        StAluWb,
        StBeq,
        StJal
    } ty_STATE;

    typedef enum logic [1:0] {
        ResAluOut     = 2'b00,
        ResDataMemory = 2'b01,
        ResAluResult  = 2'b10
    } ty_RESULT_SRC;

    typedef enum logic [1:0] {
        SrcAPc    = 2'd0,
        SrcAOldPc = 2'd1,
        SrcARd1   = 2'd2
    } ty_ALU_SRC_A;

    typedef enum logic [1:0] {
        SrcBRd2  = 2'd0,
        SrcBImm  = 2'd1,
        SrcBFour = 2'd2
    } ty_ALU_SRC_B;

endpackage

// File: rtl/mc_alu_decoder.sv
// Combinational funct3/funct7b5 decode to an ALU operation; I-type ignores
// funct7b5 so that ADDI never turns into a subtract.
module mc_alu_decoder
    import mc_control_fsm_pkg::*;
(
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    input  logic       i_is_r_type,
    output ty_ALU_OP   o_alu_op
);

    always_comb begin
        o_alu_op = AluAdd;
        case (i_funct3)
            3'b000:  o_alu_op = (i_is_r_type && i_funct7b5) ? AluSub : AluAdd;
            3'b100:  o_alu_op = AluXor;
            3'b110:  o_alu_op = AluOr;
            3'b111:  o_alu_op = AluAnd;
            default: o_alu_op = AluAdd;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Main control FSM of the multi-cycle core: sequences fetch/decode/execute over a
// shared memory and stalls fetch, load and store on the memory-ready handshake.
module mc_control_fsm
    import mc_control_fsm_pkg::*;
#(
    parameter int unsigned RESET_TO_FETCH = 1,
    parameter bit          CHECK_ILLEGAL  = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    input  logic       i_zero,
    input  logic       i_memReady,
    output logic       o_pcWrite,
    output logic       o_adrSrc,
    output logic       o_memWrite,
    output logic       o_irWrite,
    output logic       o_regWrite,
    output logic [1:0] o_resultSrc,
    output logic [1:0] o_aluSrcA,
    output logic [1:0] o_aluSrcB,
    output logic [3:0] o_aluControl,
    output logic       o_retire,
    output logic       o_illegal
);

    ty_STATE  r_state;
    ty_STATE  w_state_next;
    ty_ALU_OP w_alu_op;
    logic     w_is_r_type;
    logic     w_opcode_legal;

    generate
        if (RESET_TO_FETCH != 1) begin : g_bad_reset_state
            $error("mc_control_fsm: only RESET_TO_FETCH = 1 is supported");
        end
    endgenerate

    assign w_is_r_type    = (r_state == StExecuteR);
    assign w_opcode_legal = i_opcode inside {OpLoad, OpStore, OpRType, OpIType, OpBType, OpJal};

    mc_alu_decoder u_alu_decoder (
        .i_funct3    (i_funct3),
        .i_funct7b5  (i_funct7b5),
        .i_is_r_type (w_is_r_type),
        .o_alu_op    (w_alu_op)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= StFetch;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = StFetch;
        case (r_state)
            StFetch:    w_state_next = i_memReady ? StDecode : StFetch;
            StDecode: begin
                case (i_opcode)
                    OpLoad, OpStore: w_state_next = StMemAdr;
                    OpRType:         w_state_next = StExecuteR;
                    OpIType:         w_state_next = StExecuteI;
                    OpBType:         w_state_next = StBeq;
                    OpJal:           w_state_next = StJal;
                    default:         w_state_next = StFetch;
                endcase
            end
            StMemAdr:   w_state_next = (i_opcode == OpStore) ? StMemWrite : StMemRead;
            StMemRead:  w_state_next = i_memReady ? StMemWb : StMemRead;
            StMemWb:    w_state_next = StFetch;
            StMemWrite: w_state_next = i_memReady ? StFetch : StMemWrite;
            StExecuteR: w_state_next = StAluWb;
            StExecuteI: w_state_next = StAluWb;
            StAluWb:    w_state_next = StFetch;
            StBeq:      w_state_next = StFetch;
            StJal:      w_state_next = StAluWb;
            default:    w_state_next = StFetch;
        endcase
    end

    always_comb begin
        o_pcWrite    = 1'b0;
        o_adrSrc     = 1'b0;
        o_memWrite   = 1'b0;
        o_irWrite    = 1'b0;
        o_regWrite   = 1'b0;
        o_resultSrc  = ResAluOut;
        o_aluSrcA    = SrcAPc;
        o_aluSrcB    = SrcBRd2;
        o_aluControl = AluAdd;
        o_retire     = 1'b0;
        o_illegal    = 1'b0;
        case (r_state)
            StFetch: begin
                o_aluSrcB   = SrcBFour;
                o_resultSrc = ResAluResult;
                o_irWrite   = i_memReady;
                o_pcWrite   = i_memReady;
            end
            // Branch/jump target is precomputed here into ALUOut.
            StDecode: begin
                o_aluSrcA = SrcAOldPc;
                o_aluSrcB = SrcBImm;
                o_illegal = CHECK_ILLEGAL && !w_opcode_legal;
            end
            StMemAdr: begin
                o_aluSrcA = SrcARd1;
                o_aluSrcB = SrcBImm;
            end
            StMemRead: o_adrSrc = 1'b1;
            StMemWb: begin
                o_resultSrc = ResDataMemory;
                o_regWrite  = 1'b1;
                o_retire    = 1'b1;
            end
            StMemWrite: begin
                o_adrSrc   = 1'b1;
                o_memWrite = 1'b1;
                o_retire   = i_memReady;
            end
            StExecuteR: begin
                o_aluSrcA    = SrcARd1;
                o_aluControl = w_alu_op;
            end
            StExecuteI: begin
                o_aluSrcA    = SrcARd1;
                o_aluSrcB    = SrcBImm;
                o_aluControl = w_alu_op;
            end
            StAluWb: begin
                o_regWrite = 1'b1;
                o_retire   = 1'b1;
            end
            StBeq: begin
                o_aluSrcA    = SrcARd1;
                o_aluControl = AluSub;
                o_pcWrite    = i_zero;
                o_retire     = 1'b1;
            end
            StJal: begin
                o_aluSrcA = SrcAOldPc;
                o_aluSrcB = SrcBFour;
                o_pcWrite = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
